// File: rtl/result_writer_if.sv
// result_writer_if: element stream and read port of the result writer.
//   i_en / i_value_i / i_data : element strobe, index tag, element value
//   i_rd_en / i_rd_addr       : read request and address
//   o_rd_data / o_rd_valid    : read data (1-cycle latency) and its valid flag
// Modports: master = producer/host side, slave = result_writer.
interface result_writer_if #(
    parameter int unsigned SIZE_ADDR = 8,
    parameter int unsigned SIZE_DATA = 32
);
    logic                 i_en;
    logic [SIZE_ADDR-1:0] i_value_i;
    logic [SIZE_DATA-1:0] i_data;
    logic                 i_rd_en;
    logic [SIZE_ADDR-1:0] i_rd_addr;
    logic [SIZE_DATA-1:0] o_rd_data;
    logic                 o_rd_valid;

    modport master (
        output i_en, i_value_i, i_data, i_rd_en, i_rd_addr,
        input  o_rd_data, o_rd_valid
    );

    modport slave (
        input  i_en, i_value_i, i_data, i_rd_en, i_rd_addr,
        output o_rd_data, o_rd_valid
    );
endinterface

// File: rtl/result_writer.sv
// result_writer: captures an enable/index/data element stream into an internal
// buffer in arrival order, counts elements, pulses o_done when the target count
// is reached and offers a synchronous read port.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_num_elems    : target count, sampled on i_start (0 = 2**SIZE_ADDR)
//   i_start        : begin a new collection (clears count and error)
//   o_count        : elements captured in the current collection
//   o_busy         : collection in progress
//   o_done         : one-cycle completion pulse
//   o_err          : sticky index-order / overflow error
//   bus            : result_writer_if.slave (element stream + read port)
// Optional feature: define RESULT_WRITER_IDX_CHECK_EN to build the index checker;
// otherwise i_value_i is unused and o_err is tied low.
module result_writer #(
    parameter int unsigned SIZE_ADDR = 8,
    parameter int unsigned SIZE_DATA = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [SIZE_ADDR-1:0] i_num_elems,
    input  logic                 i_start,
    output logic [SIZE_ADDR:0]   o_count,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    result_writer_if.slave       bus
);
    localparam int unsigned DEPTH = 1 << SIZE_ADDR;
    localparam int unsigned CNT_W = SIZE_ADDR + 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     target_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_inc;
    logic [SIZE_ADDR-1:0] wr_ptr_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 rd_valid_q;
    logic [SIZE_DATA-1:0] rd_data_q;
    logic                 wr_accept;
    logic                 last_wr;

    logic [SIZE_DATA-1:0] mem [DEPTH];

    assign count_inc = count_q + CNT_W'(1);

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start wins over everything, including the final write
    always_comb begin
        state_d = state_q;
        if (i_start) begin
            state_d = S_COLLECT;
        end else begin
            case (state_q)
                S_COLLECT: if (last_wr) state_d = S_DONE;
                default:   state_d = state_q;
            endcase
        end
    end

    // Output/control decode: element acceptance only in COLLECT without start
    always_comb begin
        wr_accept = 1'b0;
        last_wr   = 1'b0;
        if (!i_start && state_q == S_COLLECT && bus.i_en) begin
            wr_accept = 1'b1;
            last_wr   = (count_inc == target_q);
        end
    end

    // Counters, target and registered status outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            target_q   <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            busy_q     <= (state_d == S_COLLECT);
            done_q     <= last_wr;
            rd_valid_q <= bus.i_rd_en;
            if (bus.i_rd_en) begin
                rd_data_q <= mem[bus.i_rd_addr];
            end
            if (i_start) begin
                // 0 encodes a full-depth collection
                target_q <= (i_num_elems == '0) ? CNT_W'(DEPTH) : CNT_W'(i_num_elems);
                count_q  <= '0;
                wr_ptr_q <= '0;
            end else if (wr_accept) begin
                count_q  <= count_inc;
                wr_ptr_q <= wr_ptr_q + SIZE_ADDR'(1);
            end
        end
    end

    // Buffer write; not reset, and the read above sees the pre-write contents
    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_accept) begin
            mem[wr_ptr_q] <= bus.i_data;
        end
    end

`ifdef RESULT_WRITER_IDX_CHECK_EN
    logic err_q;
    logic err_set;

    // Out-of-order index while collecting, or any strobe after completion
    always_comb begin
        err_set = 1'b0;
        if (!i_start && bus.i_en) begin
            case (state_q)
                S_COLLECT: err_set = (bus.i_value_i != wr_ptr_q);
                S_DONE:    err_set = 1'b1;
                default:   err_set = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (i_start) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    logic unused_value_i;
    assign unused_value_i = ^bus.i_value_i;
    assign o_err          = 1'b0;
`endif

    assign o_count        = count_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign bus.o_rd_valid = rd_valid_q;
    assign bus.o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: directed scoreboard bench for result_writer. Read
// expectations are queued at issue time and checked by a monitor when
// o_rd_valid is seen; status outputs are checked inline after each edge.
module tb_result_writer;
    localparam int unsigned SA = 8;
    localparam int unsigned SD = 32;
`ifdef RESULT_WRITER_IDX_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    typedef struct {
        logic [SA-1:0] addr;
        logic [SD-1:0] data;
    } rd_exp_t;

    logic          clk;
    logic          rst_n;
    logic [SA-1:0] num_elems;
    logic          start;
    logic [SA:0]   count;
    logic          busy;
    logic          done;
    logic          err;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    rd_exp_t exp_q[$];

    result_writer_if #(.SIZE_ADDR(SA), .SIZE_DATA(SD)) bus ();

    result_writer #(.SIZE_ADDR(SA), .SIZE_DATA(SD)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_num_elems (num_elems),
        .i_start     (start),
        .o_count     (count),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read-data monitor
    always @(negedge clk) begin
        rd_exp_t e;
        if (done === 1'b1) done_cnt++;
        if (bus.o_rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got data 0x%0h with no read pending at %0t",
                         bus.o_rd_data, $time);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rd[%0d]", e.addr), 64'(bus.o_rd_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [SA-1:0] idx, input logic [SD-1:0] d);
        bus.i_en      = 1'b1;
        bus.i_value_i = idx;
        bus.i_data    = d;
        step();
        bus.i_en      = 1'b0;
    endtask

    task automatic do_start(input logic [SA-1:0] n);
        start     = 1'b1;
        num_elems = n;
        step();
        start     = 1'b0;
    endtask

    task automatic rd(input logic [SA-1:0] a, input logic [SD-1:0] d);
        rd_exp_t e;
        e.addr        = a;
        e.data        = d;
        exp_q.push_back(e);
        bus.i_rd_en   = 1'b1;
        bus.i_rd_addr = a;
        step();
        bus.i_rd_en   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_rd_valid"}, 64'(bus.o_rd_valid), 64'd0);
        check({tag, "_rd_data"}, 64'(bus.o_rd_data), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        num_elems     = '0;
        bus.i_en      = 1'b0;
        bus.i_value_i = '0;
        bus.i_data    = '0;
        bus.i_rd_en   = 1'b0;
        bus.i_rd_addr = '0;

        // Reset state
        step();
        step();
        check_zero("reset");
        rst_n = 1'b1;
        step();

        // Strobes in IDLE are ignored and raise no error
        strobe(8'd0, 32'hDEAD);
        check("idle_count", 64'(count), 64'd0);
        check("idle_err", 64'(err), 64'd0);

        // Normal run of 4
        do_start(8'd4);
        check("norm_busy", 64'(busy), 64'd1);
        check("norm_count0", 64'(count), 64'd0);
        for (int k = 0; k < 4; k++) begin
            strobe(SA'(k), 32'h10 + 32'(k));
            if (k < 3) check($sformatf("norm_done_early%0d", k), 64'(done), 64'd0);
        end
        check("norm_done", 64'(done), 64'd1);
        check("norm_count", 64'(count), 64'd4);
        check("norm_busy_fall", 64'(busy), 64'd0);
        step();
        check("norm_done_once", 64'(done), 64'd0);
        for (int k = 0; k < 4; k++) rd(SA'(k), 32'h10 + 32'(k));

        // Gapped run of 3, then overflow strobe in DONE
        do_start(8'd3);
        for (int k = 0; k < 3; k++) begin
            strobe(SA'(k), 32'h20 + 32'(k));
            if (k < 2) begin
                step();
                step();
            end
        end
        check("gap_done", 64'(done), 64'd1);
        check("gap_count", 64'(count), 64'd3);
        strobe(8'd3, 32'hBAD);
        check("ovf_err", 64'(err), 64'(CHK));
        check("ovf_count", 64'(count), 64'd3);
        for (int k = 0; k < 3; k++) rd(SA'(k), 32'h20 + 32'(k));
        rd(8'd3, 32'h13);

        // Start together with a strobe: start wins, element dropped
        do_start(8'd5);
        strobe(8'd0, 32'h30);
        strobe(8'd1, 32'h31);
        start         = 1'b1;
        num_elems     = 8'd5;
        bus.i_en      = 1'b1;
        bus.i_value_i = 8'd2;
        bus.i_data    = 32'h99;
        step();
        start    = 1'b0;
        bus.i_en = 1'b0;
        check("sim_count", 64'(count), 64'd0);
        check("sim_busy", 64'(busy), 64'd1);
        check("sim_err", 64'(err), 64'd0);
        rd(8'd2, 32'h22);

        // Read and write of address 0 in one cycle returns the old data
        exp_q.push_back('{addr: 8'd0, data: 32'h30});
        bus.i_rd_en   = 1'b1;
        bus.i_rd_addr = 8'd0;
        strobe(8'd0, 32'h40);
        bus.i_rd_en   = 1'b0;
        for (int k = 1; k < 5; k++) strobe(SA'(k), 32'h40 + 32'(k));
        check("sim_done", 64'(done), 64'd1);
        check("sim_count5", 64'(count), 64'd5);
        for (int k = 0; k < 5; k++) rd(SA'(k), 32'h40 + 32'(k));

        // Index mismatch: indices 0,2,2
        do_start(8'd3);
        strobe(8'd0, 32'h50);
        check("mis_err0", 64'(err), 64'd0);
        strobe(8'd2, 32'h51);
        check("mis_err1", 64'(err), 64'(CHK));
        strobe(8'd2, 32'h52);
        check("mis_err2", 64'(err), 64'(CHK));
        check("mis_done", 64'(done), 64'd1);
        rd(8'd1, 32'h51);

        // New start clears the error; reset after 2 of 5
        do_start(8'd5);
        check("restart_err", 64'(err), 64'd0);
        strobe(8'd0, 32'h60);
        strobe(8'd1, 32'h61);
        check("rst_pre_count", 64'(count), 64'd2);
        rst_n = 1'b0;
        step();
        check_zero("rst_mid");
        rst_n = 1'b1;
        for (int k = 2; k < 5; k++) begin
            strobe(SA'(k), 32'h62);
            check($sformatf("rst_ign_count%0d", k), 64'(count), 64'd0);
            check($sformatf("rst_ign_done%0d", k), 64'(done), 64'd0);
        end
        rd(8'd0, 32'h60);
        rd(8'd2, 32'h52);
        step();
        check("rd_hold", 64'(bus.o_rd_data), 64'h52);
        check("rd_valid_low", 64'(bus.o_rd_valid), 64'd0);

        // Full depth: N = 0 means 256
        do_start(8'd0);
        for (int k = 0; k < 256; k++) begin
            strobe(SA'(k), 32'h1000 + 32'(k));
            if (k == 254) begin
                check("full_count255", 64'(count), 64'd255);
                check("full_done_early", 64'(done), 64'd0);
            end
        end
        check("full_done", 64'(done), 64'd1);
        check("full_count", 64'(count), 64'd256);
        check("full_busy", 64'(busy), 64'd0);
        rd(8'd0, 32'h1000);
        rd(8'd128, 32'h1080);
        rd(8'd255, 32'h10FF);
        step();
        step();

        check("done_pulses", 64'(done_cnt), 64'd5);
        check("rd_pending", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
